// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: 7-segment pattern constants, bit0=a .. bit6=g (active-high), and the numeral lookup table
package seg_scan_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0 = 7'b0111111;
  localparam seg_t SEG_1 = 7'b0000110;
  localparam seg_t SEG_2 = 7'b1011011;
  localparam seg_t SEG_3 = 7'b1001111;
  localparam seg_t SEG_4 = 7'b1100110;
  localparam seg_t SEG_5 = 7'b1101101;
  localparam seg_t SEG_6 = 7'b1111101;
  localparam seg_t SEG_7 = 7'b0000111;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display bus (seg, dig_en) in, decoded digits/valid/err/upd/upd_idx out
interface seg_scan_decoder_if #(parameter int NUM_DIGITS = 4);
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] dig_en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0] valid;
  logic [NUM_DIGITS-1:0] err;
  logic upd;
  logic [IDX_W-1:0] upd_idx;
  modport master(output seg, dig_en, input digits, valid, err, upd, upd_idx);
  modport slave(input seg, dig_en, output digits, valid, err, upd, upd_idx);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: seg[6:0] -> hit (legal numeral), blank (all off), value[3:0]
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);
  always_comb begin
    hit = 1'b0;
    value = 4'd0;
    for (int i = 0; i < 10; i++)
      if (seg == SEG_TABLE[i]) begin
        hit = 1'b1;
        value = 4'(i);
      end
  end
  assign blank = seg == SEG_BLANK;
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: clk, rst (async high), bus.slave; stability-filtered readback of a multiplexed 7-seg bus into per-digit values
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg_scan_decoder_if.slave bus
);
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  logic [6:0] seg_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic [CNT_W-1:0] cnt;
  logic blk;
  logic hit, blank;
  logic [3:0] value;
  logic same, commit;
  logic [IDX_W-1:0] idx;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0] valid_q, err_q;
  logic upd_q;
  logic [IDX_W-1:0] upd_idx_q;
  seg_pattern_decode u_dec (.seg(seg_q), .hit(hit), .blank(blank), .value(value));
  assign same = {bus.seg, bus.dig_en} == {seg_q, en_q};
  assign commit = !blk && same && cnt == CNT_W'(STABLE_CYCLES - 1) && $onehot(en_q);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (en_q[i]) idx = IDX_W'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_q <= '0;
      en_q <= '0;
      cnt <= '0;
      blk <= 1'b1;
    end else if (cnt == '0 || !same) begin
      seg_q <= bus.seg;
      en_q <= bus.dig_en;
      cnt <= CNT_W'(1);
      blk <= blk && cnt == '0;
    end else if (cnt != CNT_W'(STABLE_CYCLES)) cnt <= cnt + CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      digits_q <= '0;
      valid_q <= '0;
      err_q <= '0;
      upd_q <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      upd_q <= commit;
      if (commit) begin
        upd_idx_q <= idx;
        valid_q[idx] <= hit;
        err_q[idx] <= !hit && !blank;
        if (hit || blank) digits_q[{idx, 2'b00} +: 4] <= hit ? value : 4'd0;
      end
    end
  assign bus.digits = digits_q;
  assign bus.valid = valid_q;
  assign bus.err = err_q;
  assign bus.upd = upd_q;
  assign bus.upd_idx = upd_idx_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int ups = 0;
  seg_scan_decoder_if #(.NUM_DIGITS(4)) b ();
  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (b.upd) ups++;
    end
  endtask
  task automatic drive(input logic [6:0] s, input logic [3:0] e);
    b.seg = s;
    b.dig_en = e;
    ups = 0;
  endtask
  task automatic test_reset;
    drive(7'b0, 4'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (b.digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h want %h", b.digits, 16'h0); end
    checks++; if (b.valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want %b", b.valid, 4'b0); end
    checks++; if (b.err !== 4'b0) begin errors++; $display("FAIL reset_err: got %b want %b", b.err, 4'b0); end
    checks++; if ({b.upd, b.upd_idx} !== 3'b0) begin errors++; $display("FAIL reset_upd: got %b want %b", {b.upd, b.upd_idx}, 3'b0); end
    run(20);
    checks++; if (ups !== 0) begin errors++; $display("FAIL reset_idle_upd: got %0d want %0d", ups, 0); end
  endtask
  task automatic test_latency;
    drive(7'b1011011, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checks++; if (b.upd !== (k == 3)) begin errors++; $display("FAIL lat_upd_e%0d: got %b want %b", k, b.upd, k == 3); end
    end
    checks++; if (b.upd_idx !== 2'd0) begin errors++; $display("FAIL lat_idx: got %0d want %0d", b.upd_idx, 0); end
    checks++; if (b.digits[3:0] !== 4'd2) begin errors++; $display("FAIL lat_digit: got %h want %h", b.digits[3:0], 4'd2); end
    checks++; if (b.valid !== 4'b0001) begin errors++; $display("FAIL lat_valid: got %b want %b", b.valid, 4'b0001); end
    checks++; if (b.err !== 4'b0) begin errors++; $display("FAIL lat_err: got %b want %b", b.err, 4'b0); end
  endtask
  task automatic test_scan;
    logic [6:0] pat [4];
    pat = '{7'b0000110, 7'b1101111, 7'b0000111, 7'b0111111};
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 4'(1 << i));
      run(5);
      checks++; if (ups !== 1 || b.upd_idx !== 2'(i)) begin errors++; $display("FAIL scan_upd%0d: got %0d/%0d want 1/%0d", i, ups, b.upd_idx, i); end
    end
    checks++; if (b.digits !== 16'h0791) begin errors++; $display("FAIL scan_digits: got %h want %h", b.digits, 16'h0791); end
    checks++; if (b.valid !== 4'b1111) begin errors++; $display("FAIL scan_valid: got %b want %b", b.valid, 4'b1111); end
  endtask
  task automatic test_illegal;
    drive(7'b1110110, 4'b0100);
    run(5);
    checks++; if (b.err !== 4'b0100) begin errors++; $display("FAIL ill_err: got %b want %b", b.err, 4'b0100); end
    checks++; if (b.valid !== 4'b1011) begin errors++; $display("FAIL ill_valid: got %b want %b", b.valid, 4'b1011); end
    checks++; if (b.digits[11:8] !== 4'd7) begin errors++; $display("FAIL ill_digit: got %h want %h", b.digits[11:8], 4'd7); end
    checks++; if (ups !== 1 || b.upd_idx !== 2'd2) begin errors++; $display("FAIL ill_upd: got %0d/%0d want 1/2", ups, b.upd_idx); end
  endtask
  task automatic test_glitch_multihot;
    drive(7'b0000110, 4'b0001);
    run(2);
    checks++; if (ups !== 0) begin errors++; $display("FAIL glitch_upd: got %0d want %0d", ups, 0); end
    drive(7'b1111111, 4'b0001);
    run(5);
    checks++; if (ups !== 1 || b.digits !== 16'h0798) begin errors++; $display("FAIL glitch_commit: got %0d/%h want 1/%h", ups, b.digits, 16'h0798); end
    drive(7'b1111111, 4'b0011);
    run(10);
    checks++; if (ups !== 0) begin errors++; $display("FAIL multi_upd: got %0d want %0d", ups, 0); end
    checks++; if ({b.digits, b.valid, b.err} !== {16'h0798, 4'b1011, 4'b0100}) begin errors++; $display("FAIL multi_hold: got %h want %h", {b.digits, b.valid, b.err}, {16'h0798, 4'b1011, 4'b0100}); end
  endtask
  task automatic test_reset_midqual;
    drive(7'b1101101, 4'b0010);
    run(2);
    rst = 1'b1;
    #1;
    checks++; if ({b.digits, b.valid, b.err, b.upd} !== 25'h0) begin errors++; $display("FAIL mid_async: got %h want %h", {b.digits, b.valid, b.err, b.upd}, 25'h0); end
    run(2);
    rst = 1'b0;
    run(10);
    checks++; if (ups !== 0) begin errors++; $display("FAIL mid_upd: got %0d want %0d", ups, 0); end
    checks++; if ({b.digits, b.valid, b.err} !== 24'h0) begin errors++; $display("FAIL mid_outs: got %h want %h", {b.digits, b.valid, b.err}, 24'h0); end
    drive(7'b1001111, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++; if (b.upd !== (k == 3)) begin errors++; $display("FAIL mid_resume_e%0d: got %b want %b", k, b.upd, k == 3); end
    end
    checks++; if (b.digits !== 16'h0030 || b.valid !== 4'b0010) begin errors++; $display("FAIL mid_resume: got %h/%b want %h/%b", b.digits, b.valid, 16'h0030, 4'b0010); end
  endtask
  task automatic test_restrobe_blank;
    drive(7'b1001111, 4'b0001);
    run(5);
    checks++; if (ups !== 1 || b.upd_idx !== 2'd0) begin errors++; $display("FAIL re_d0: got %0d/%0d want 1/0", ups, b.upd_idx); end
    drive(7'b1001111, 4'b0010);
    run(5);
    checks++; if (ups !== 1 || b.upd_idx !== 2'd1) begin errors++; $display("FAIL re_d1: got %0d/%0d want 1/1", ups, b.upd_idx); end
    checks++; if (b.digits !== 16'h0033) begin errors++; $display("FAIL re_digits: got %h want %h", b.digits, 16'h0033); end
    drive(7'b0000000, 4'b0010);
    run(5);
    checks++; if ({b.digits, b.valid, b.err} !== {16'h0003, 4'b0001, 4'b0000}) begin errors++; $display("FAIL blank: got %h want %h", {b.digits, b.valid, b.err}, {16'h0003, 4'b0001, 4'b0000}); end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_scan;
    test_illegal;
    test_glitch_multihot;
    test_reset_midqual;
    test_restrobe_blank;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
